vga_output_stage: RTL and testbench

- Final pixel-path stage between the disc controller's 1-bit RGB outputs and the VGA_R/G/B/HS/VS pins.
- Delays the sync and blank signals from the sync generator by a fixed number of pixel enables so they line up with the controller's colour pipeline.
- Registers all pin outputs, forces black during blanking, replicates 1-bit colour to 4 bits, and holds the display dark after reset until the first full frame boundary.

---
 rtl/vga_pkg.sv | 30 +++
 rtl/vga_delay_line.sv | 38 +++
 rtl/vga_output_stage.sv | 195 +++++++++++++++++++
 tb/tb_vga_output_stage.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared types and constants for the VGA output stage.
//   vga_state_e   : alignment state machine states
//   sync_bundle_t : {hs, vs, blank} carried through the sync delay line
//   idle_bundle() : delay-line reset/idle contents for a given sync polarity
package vga_pkg;

    localparam int unsigned COLOR_W_DEFAULT = 4;

    typedef enum logic [1:0] {
        StWaitVs  = 2'd0,
        StWaitEnd = 2'd1,
        StRun     = 2'd2
    } vga_state_e;

    typedef struct packed {
        logic hs;
        logic vs;
        logic blank;
    } sync_bundle_t;

    // Syncs at their idle level, blank asserted.
    function automatic sync_bundle_t idle_bundle(input logic sync_idle);
        sync_bundle_t b;
        b.hs    = sync_idle;
        b.vs    = sync_idle;
        b.blank = 1'b1;
        return b;
    endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Enable-gated shift register for the {hs, vs, blank} bundle.
//   clk, rst  : clock, asynchronous active-high reset (contents -> idle, blank = 1)
//   en        : shift strobe (pixel enable)
//   din       : undelayed bundle
//   dout      : bundle delayed by DEPTH strobes; DEPTH = 0 is a pass-through
module vga_delay_line
    import vga_pkg::*;
#(
    parameter int unsigned DEPTH     = 2,
    parameter logic        SYNC_IDLE = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  sync_bundle_t din,
    output sync_bundle_t dout
);

    if (DEPTH == 0) begin : g_bypass
        assign dout = din;
    end else begin : g_shift
        sync_bundle_t [DEPTH-1:0] stages_q;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                stages_q <= {DEPTH{idle_bundle(SYNC_IDLE)}};
            end else if (en) begin
                stages_q[0] <= din;
                for (int unsigned i = 1; i < DEPTH; i++) begin
                    stages_q[i] <= stages_q[i-1];
                end
            end
        end

        assign dout = stages_q[DEPTH-1];
    end

endmodule

// File: rtl/vga_output_stage.sv
// Final pixel-path stage: delays raw sync/blank to line up with the colour pipeline,
// registers all pin outputs on pix_en, blacks out blanking, replicates 1-bit colour to
// COLOR_W bits and keeps the display dark after reset until a full vsync pulse is seen.
//   clk, rst             : clock, asynchronous active-high reset
//   pix_en               : pixel strobe; every pipeline advance is qualified by it
//   hsync_in, vsync_in   : raw syncs (pin polarity)
//   blank_in             : 1 = outside the active region
//   red_in..blue_in      : 1-bit colour, already SYNC_DELAY pixels late
//   vga_r, vga_g, vga_b  : COLOR_W-bit pin colour
//   vga_hs, vga_vs       : pin syncs
//   frame_start          : one-clk pulse on the first active pixel of each frame
//   aligned              : state machine has reached RUN
// Optional build macro VGA_OUT_TESTBAR_EN adds input testbar: when high in RUN, colour
// comes from bits [9:7] of an active-pixel counter ({r,g,b}), giving 8 vertical bars.
module vga_output_stage
    import vga_pkg::*;
#(
    parameter int unsigned SYNC_DELAY      = 2,
    parameter logic        SYNC_ACTIVE_LOW = 1'b1,
    parameter int unsigned COLOR_W         = COLOR_W_DEFAULT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               pix_en,
    input  logic               hsync_in,
    input  logic               vsync_in,
    input  logic               blank_in,
    input  logic               red_in,
    input  logic               green_in,
    input  logic               blue_in,
`ifdef VGA_OUT_TESTBAR_EN
    input  logic               testbar,
`endif
    output logic [COLOR_W-1:0] vga_r,
    output logic [COLOR_W-1:0] vga_g,
    output logic [COLOR_W-1:0] vga_b,
    output logic               vga_hs,
    output logic               vga_vs,
    output logic               frame_start,
    output logic               aligned
);

    // The parameter only fixes the idle level; inputs already arrive in pin polarity.
    localparam logic SYNC_IDLE = SYNC_ACTIVE_LOW;

    sync_bundle_t raw_sync;
    sync_bundle_t tap;

    assign raw_sync.hs    = hsync_in;
    assign raw_sync.vs    = vsync_in;
    assign raw_sync.blank = blank_in;

    vga_delay_line #(
        .DEPTH     (SYNC_DELAY),
        .SYNC_IDLE (SYNC_IDLE)
    ) u_delay_line (
        .clk  (clk),
        .rst  (rst),
        .en   (pix_en),
        .din  (raw_sync),
        .dout (tap)
    );

    vga_state_e         state_q, state_d;
    logic               frame_armed_q, frame_armed_d;
    logic               blank_q, blank_d;
    logic               hs_q, hs_d;
    logic               vs_q, vs_d;
    logic [COLOR_W-1:0] r_q, r_d;
    logic [COLOR_W-1:0] g_q, g_d;
    logic [COLOR_W-1:0] b_q, b_d;
    logic               frame_start_q, frame_start_d;

    logic               vs_act_prev, vs_act_now;
    logic               vs_assert, vs_deassert;
    logic               blank_fall;
    logic               armed_now;
    logic               show;
    logic [2:0]         pix_rgb;

`ifdef VGA_OUT_TESTBAR_EN
    logic [9:0]         cnt_q, cnt_d;
    logic               blank_rise;
`endif

    // Edges are taken between the registered (previous) delayed value and the current tap,
    // so they only ever fire on pix_en cycles.
    always_comb begin
        vs_act_prev = vs_q ^ SYNC_ACTIVE_LOW;
        vs_act_now  = tap.vs ^ SYNC_ACTIVE_LOW;
        vs_assert   = pix_en && !vs_act_prev && vs_act_now;
        vs_deassert = pix_en && vs_act_prev && !vs_act_now;
        blank_fall  = pix_en && blank_q && !tap.blank;
    end

    // Alignment FSM: dark until one complete delayed vsync pulse has been seen.
    always_comb begin
        state_d = state_q;
        case (state_q)
            StWaitVs:  if (vs_assert)   state_d = StWaitEnd;
            StWaitEnd: if (vs_deassert) state_d = StRun;
            StRun:     state_d = StRun;
            default:   state_d = StWaitVs;
        endcase
    end

    // vsync is handled before blank on the same pixel: a deassertion arms the flag and
    // the next-state is used, so a coincident blank fall already counts as in RUN.
    always_comb begin
        frame_armed_d = frame_armed_q;
        frame_start_d = 1'b0;
        armed_now     = frame_armed_q || vs_deassert;
        if (state_d == StRun && blank_fall && armed_now) begin
            frame_start_d = 1'b1;
            frame_armed_d = 1'b0;
        end else if (vs_deassert) begin
            frame_armed_d = 1'b1;
        end
    end

`ifdef VGA_OUT_TESTBAR_EN
    always_comb begin
        blank_rise = pix_en && !blank_q && tap.blank;
        cnt_d      = cnt_q;
        if (blank_rise) begin
            cnt_d = '0;
        end else if (pix_en && !tap.blank) begin
            cnt_d = cnt_q + 10'd1;
        end
        pix_rgb = testbar ? cnt_q[9:7] : {red_in, green_in, blue_in};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    assign pix_rgb = {red_in, green_in, blue_in};
`endif

    // Output register: holds everything, syncs included, while pix_en is low.
    always_comb begin
        show    = (state_d == StRun) && !tap.blank;
        hs_d    = hs_q;
        vs_d    = vs_q;
        blank_d = blank_q;
        r_d     = r_q;
        g_d     = g_q;
        b_d     = b_q;
        if (pix_en) begin
            hs_d    = tap.hs;
            vs_d    = tap.vs;
            blank_d = tap.blank;
            r_d     = show ? {COLOR_W{pix_rgb[2]}} : '0;
            g_d     = show ? {COLOR_W{pix_rgb[1]}} : '0;
            b_d     = show ? {COLOR_W{pix_rgb[0]}} : '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= StWaitVs;
            frame_armed_q <= 1'b0;
            blank_q       <= 1'b1;
            hs_q          <= SYNC_IDLE;
            vs_q          <= SYNC_IDLE;
            r_q           <= '0;
            g_q           <= '0;
            b_q           <= '0;
            frame_start_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            frame_armed_q <= frame_armed_d;
            blank_q       <= blank_d;
            hs_q          <= hs_d;
            vs_q          <= vs_d;
            r_q           <= r_d;
            g_q           <= g_d;
            b_q           <= b_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign vga_r       = r_q;
    assign vga_g       = g_q;
    assign vga_b       = b_q;
    assign vga_hs      = hs_q;
    assign vga_vs      = vs_q;
    assign frame_start = frame_start_q;
    assign aligned     = (state_q == StRun);

endmodule

// File: tb/tb_vga_output_stage.sv
// Directed table-driven bench for vga_output_stage at default parameters
// (SYNC_DELAY = 2, active-low syncs, 4-bit colour). One vector = one pix_en strobe
// followed by one idle clock; outputs are sampled on the falling edge after the strobe.
module tb_vga_output_stage;

    logic       clk;
    logic       rst;
    logic       pix_en;
    logic       hsync_in, vsync_in, blank_in;
    logic       red_in, green_in, blue_in;
    logic       testbar;
    logic [3:0] vga_r, vga_g, vga_b;
    logic       vga_hs, vga_vs, frame_start, aligned;

    int checks   = 0;
    int failures = 0;

    vga_output_stage dut (
        .clk         (clk),
        .rst         (rst),
        .pix_en      (pix_en),
        .hsync_in    (hsync_in),
        .vsync_in    (vsync_in),
        .blank_in    (blank_in),
        .red_in      (red_in),
        .green_in    (green_in),
        .blue_in     (blue_in),
`ifdef VGA_OUT_TESTBAR_EN
        .testbar     (testbar),
`endif
        .vga_r       (vga_r),
        .vga_g       (vga_g),
        .vga_b       (vga_b),
        .vga_hs      (vga_hs),
        .vga_vs      (vga_vs),
        .frame_start (frame_start),
        .aligned     (aligned)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        hs, vs, bl;
        logic [2:0]  rgb;
        logic [15:0] exp;   // {hs, vs, r[3:0], g[3:0], b[3:0], frame_start, aligned}
    } vec_t;

    vec_t tab [34];

    function automatic vec_t mk(input logic hs, input logic vs, input logic bl,
                                input logic [2:0] rgb, input logic ehs, input logic evs,
                                input logic [2:0] ecol, input logic efs, input logic eal);
        vec_t v;
        v.hs  = hs;
        v.vs  = vs;
        v.bl  = bl;
        v.rgb = rgb;
        v.exp = {ehs, evs, {4{ecol[2]}}, {4{ecol[1]}}, {4{ecol[0]}}, efs, eal};
        return v;
    endfunction

    task automatic check(input string name, input int idx, input logic [15:0] exp);
        logic [15:0] got;
        got = {vga_hs, vga_vs, vga_r, vga_g, vga_b, frame_start, aligned};
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s[%0d] got hs=%b vs=%b rgb=%h%h%h fs=%b al=%b, need hs=%b vs=%b rgb=%h%h%h fs=%b al=%b",
                     name, idx, got[15], got[14], got[13:10], got[9:6], got[5:2], got[1], got[0],
                     exp[15], exp[14], exp[13:10], exp[9:6], exp[5:2], exp[1], exp[0]);
        end
    endtask

    // Called on a falling edge; leaves on a falling edge.
    task automatic step(input int idx);
        hsync_in = tab[idx].hs;
        vsync_in = tab[idx].vs;
        blank_in = tab[idx].bl;
        {red_in, green_in, blue_in} = tab[idx].rgb;
        pix_en = 1'b1;
        @(negedge clk);
        pix_en = 1'b0;
        check("vec", idx, tab[idx].exp);
        @(negedge clk);
    endtask

    localparam logic [15:0] IDLE_OUT = {1'b1, 1'b1, 12'h000, 1'b0, 1'b0};

    initial begin
        // Main stream: first vsync, alignment, colour, frame_start, glitch in RUN.
        //             in: hs vs bl rgb       exp: hs vs col   fs al
        tab[0]  = mk(1, 1, 0, 3'b111, 1, 1, 3'b000, 0, 0);
        tab[1]  = mk(1, 1, 0, 3'b111, 1, 1, 3'b000, 0, 0);
        tab[2]  = mk(1, 1, 1, 3'b111, 1, 1, 3'b000, 0, 0);
        tab[3]  = mk(1, 0, 1, 3'b111, 1, 1, 3'b000, 0, 0);
        tab[4]  = mk(0, 0, 1, 3'b111, 1, 1, 3'b000, 0, 0);
        tab[5]  = mk(1, 0, 1, 3'b111, 1, 0, 3'b000, 0, 0);
        tab[6]  = mk(1, 1, 1, 3'b111, 0, 0, 3'b000, 0, 0);
        tab[7]  = mk(1, 1, 1, 3'b111, 1, 0, 3'b000, 0, 0);
        tab[8]  = mk(1, 1, 0, 3'b111, 1, 1, 3'b000, 0, 1);
        tab[9]  = mk(1, 1, 0, 3'b111, 1, 1, 3'b000, 0, 1);
        tab[10] = mk(1, 1, 0, 3'b100, 1, 1, 3'b100, 1, 1);
        tab[11] = mk(1, 1, 1, 3'b010, 1, 1, 3'b010, 0, 1);
        tab[12] = mk(1, 1, 1, 3'b111, 1, 1, 3'b111, 0, 1);
        tab[13] = mk(0, 1, 1, 3'b111, 1, 1, 3'b000, 0, 1);
        tab[14] = mk(1, 1, 0, 3'b111, 1, 1, 3'b000, 0, 1);
        tab[15] = mk(1, 1, 0, 3'b001, 0, 1, 3'b000, 0, 1);
        tab[16] = mk(1, 1, 1, 3'b001, 1, 1, 3'b001, 0, 1);
        tab[17] = mk(1, 0, 1, 3'b111, 1, 1, 3'b111, 0, 1);
        tab[18] = mk(1, 1, 0, 3'b111, 1, 1, 3'b000, 0, 1);
        tab[19] = mk(1, 1, 0, 3'b111, 1, 0, 3'b000, 0, 1);
        tab[20] = mk(1, 1, 0, 3'b111, 1, 1, 3'b111, 1, 1);
        tab[21] = mk(1, 1, 1, 3'b110, 1, 1, 3'b110, 0, 1);
        // After the pix_en hold window.
        tab[22] = mk(0, 0, 0, 3'b111, 1, 1, 3'b111, 0, 1);
        tab[23] = mk(0, 0, 0, 3'b111, 1, 1, 3'b000, 0, 1);
        tab[24] = mk(0, 0, 0, 3'b111, 0, 0, 3'b111, 0, 1);
        // After a mid-line reset: dark until a full vsync pulse.
        tab[25] = mk(1, 1, 0, 3'b111, 1, 1, 3'b000, 0, 0);
        tab[26] = mk(1, 1, 0, 3'b111, 1, 1, 3'b000, 0, 0);
        tab[27] = mk(1, 1, 0, 3'b111, 1, 1, 3'b000, 0, 0);
        tab[28] = mk(1, 0, 1, 3'b111, 1, 1, 3'b000, 0, 0);
        tab[29] = mk(1, 1, 1, 3'b111, 1, 1, 3'b000, 0, 0);
        tab[30] = mk(1, 1, 0, 3'b111, 1, 0, 3'b000, 0, 0);
        tab[31] = mk(1, 1, 0, 3'b111, 1, 1, 3'b000, 0, 1);
        tab[32] = mk(1, 1, 0, 3'b101, 1, 1, 3'b101, 1, 1);
        tab[33] = mk(1, 1, 0, 3'b111, 1, 1, 3'b111, 0, 1);

        rst      = 1'b0;
        pix_en   = 1'b0;
        hsync_in = 1'b1;
        vsync_in = 1'b1;
        blank_in = 1'b1;
        red_in   = 1'b0;
        green_in = 1'b0;
        blue_in  = 1'b0;
        testbar  = 1'b0;
        #1 rst = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_state", 0, IDLE_OUT);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i <= 21; i++) step(i);

        // pix_en low: inputs wiggle, every output must stay frozen.
        for (int i = 0; i < 10; i++) begin
            hsync_in = 1'($urandom);
            vsync_in = 1'($urandom);
            blank_in = 1'($urandom);
            {red_in, green_in, blue_in} = 3'($urandom);
            @(negedge clk);
            check("hold", i, tab[21].exp);
        end

        for (int i = 22; i <= 24; i++) step(i);

        // Asynchronous reset in the middle of a clock period.
        #2 rst = 1'b1;
        #1 check("async_reset", 0, IDLE_OUT);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 25; i <= 33; i++) step(i);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
